membank_multibyte: RTL

MEMBANK_MULTIBYTE -- requirements
Module: membank_multibyte

---
 rtl/membank_multibyte_if.sv | 26 ++
 rtl/membank_multibyte.sv | 105 ++++++++++
 2 files changed

// File: rtl/membank_multibyte_if.sv
// Request/response bundle for membank_multibyte: the requester drives the master side, the bank drives the slave side.
interface membank_multibyte_if #(
   parameter int MEM_WIDTH  = 8,
   parameter int WORD_BYTES = 2,
   parameter int ADDR_WIDTH = 16
) ();
   logic                            wr_en;
   logic                            rd_en;
   logic [ADDR_WIDTH-1:0]           index;
   logic [WORD_BYTES-1:0]           byte_en;
   logic [MEM_WIDTH*WORD_BYTES-1:0] data_in;
   logic [MEM_WIDTH*WORD_BYTES-1:0] data_out;
   logic                            rd_valid;
   logic                            addr_err;
   logic                            busy;

   modport master (
      output wr_en, rd_en, index, byte_en, data_in,
      input  data_out, rd_valid, addr_err, busy
   );

   modport slave (
      input  wr_en, rd_en, index, byte_en, data_in,
      output data_out, rd_valid, addr_err, busy
   );
endinterface

// File: rtl/membank_multibyte.sv
// Big-endian multi-byte memory bank with wrap-around, byte enables and a 1-cycle registered read.
// Requests are ignored while busy; defining MEMBANK_CLEAR_EN adds a post-reset zeroing sweep that holds busy high.
module membank_multibyte #(
   parameter int MEM_WIDTH  = 8,
   parameter int WORD_BYTES = 2,
   parameter int MEM_DEPTH  = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   membank_multibyte_if.slave bus
);
   localparam int DW = MEM_WIDTH * WORD_BYTES;
   localparam int LW = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   typedef logic [LW-1:0] loc_t;

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
   loc_t                 loc [WORD_BYTES];
   logic [DW-1:0]        rd_word;
   logic                 in_range;
   logic                 busy_i;
   logic                 wr_fire;
   logic                 rd_fire;
   logic                 err_fire;

   assign in_range = ({1'b0, bus.index} < DEPTH_EXT);
   assign wr_fire  = bus.wr_en & in_range & ~busy_i & ~rst;
   assign rd_fire  = bus.rd_en & in_range & ~busy_i & ~rst;
   assign err_fire = (bus.wr_en | bus.rd_en) & ~in_range & ~busy_i;
   assign bus.busy = busy_i;

   // Byte k (k=0 is the MSB) lives at index+k; the power-of-two depth makes the wrap a plain truncation.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         loc[k] = bus.index[LW-1:0] + loc_t'(k);
         rd_word[(WORD_BYTES-1-k)*MEM_WIDTH +: MEM_WIDTH] = mem[loc[k]];
      end
   end

`ifdef MEMBANK_CLEAR_EN
   typedef enum logic {IDLE, CLEAR} state_t;

   state_t state_q, state_d;
   loc_t   ptr_q, ptr_d;
   logic   clr_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      clr_we  = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            ptr_d  = ptr_q + loc_t'(1);
            if (ptr_q == loc_t'(MEM_DEPTH - 1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_i = (state_q == CLEAR);
`else
   assign busy_i = 1'b0;
`endif

   // Memory array has no reset; only the optional sweep ever zeroes it.
   always_ff @(posedge clk) begin
`ifdef MEMBANK_CLEAR_EN
      if (clr_we && !rst)
         mem[ptr_q] <= '0;
`endif
      for (int k = 0; k < WORD_BYTES; k++) begin
         if (wr_fire && bus.byte_en[WORD_BYTES-1-k])
            mem[loc[k]] <= bus.data_in[(WORD_BYTES-1-k)*MEM_WIDTH +: MEM_WIDTH];
      end
   end

   // Read samples pre-write contents, so a same-cycle write to the same word is not visible yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.data_out <= '0;
         bus.rd_valid <= 1'b0;
         bus.addr_err <= 1'b0;
      end else begin
         bus.rd_valid <= rd_fire;
         bus.addr_err <= err_fire;
         if (rd_fire)
            bus.data_out <= rd_word;
      end
   end
endmodule
